// File: rtl/condicionador_botoes_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : condicionador_botoes_pkg
//  Purpose  : Shared definitions for the button conditioner: button width,
//             default debounce / stuck-button windows, FSM state encoding
//             and a one-hot test helper.
//  Revision : 1.0 - initial release
// ============================================================================
package condicionador_botoes_pkg;

    localparam int C_LARGURA_BOTOES         = 4;
    localparam int C_DEBOUNCE_CICLOS_PADRAO = 50000;
    localparam int C_TRAVADO_CICLOS_PADRAO  = 5000000;

    typedef enum logic [2:0] {
        OCIOSO       = 3'd0,
        FILTRA       = 3'd1,
        VALIDA       = 3'd2,
        ESPERA_SOLTA = 3'd3,
        FILTRA_SOLTA = 3'd4
    } estado_t;

    // True when exactly one bit is set (v & (v-1) clears the lowest set bit).
    function automatic logic eh_one_hot(input logic [C_LARGURA_BOTOES-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/condicionador_botoes_sincronizador.sv
`default_nettype none
// ============================================================================
//  Module   : sincronizador
//  Purpose  : Two-flop synchronizer bringing asynchronous inputs into the
//             clock domain.
//  Ports    : clock  - system clock (rising edge)
//             reset  - asynchronous active-low reset
//             d      - asynchronous input bus [LARGURA-1:0]
//             q      - synchronized output bus [LARGURA-1:0]
//  Revision : 1.0 - initial release
// ============================================================================
module sincronizador #(
    parameter int LARGURA = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] d,
    output logic [LARGURA-1:0] q
);

    logic [LARGURA-1:0] meta_q;
    logic [LARGURA-1:0] sinc_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sinc_q <= '0;
        end else begin
            meta_q <= d;
            sinc_q <= meta_q;
        end
    end

    assign q = sinc_q;

endmodule
`default_nettype wire

// File: rtl/condicionador_botoes.sv
`default_nettype none
// ============================================================================
//  Module   : condicionador_botoes
//  Purpose  : Synchronizes and debounces four player buttons, validating
//             one-hot presses into a held jogada code with a one-cycle
//             jogada_feita pulse per physical press.
//  Ports    : clock         - system clock (rising edge)
//             reset         - asynchronous active-low reset
//             botoes[3:0]   - raw asynchronous active-high buttons
//             limpa         - synchronous clear of jogada
//             jogada[3:0]   - last validated one-hot button code
//             jogada_feita  - single-cycle pulse per validated press
//             db_tem_jogada - any synchronized button bit high
//             travado       - button held beyond TRAVADO_CICLOS
//             db_estado[2:0]- FSM state code
//  Options  : CONDICIONADOR_TRAVADO_EN - builds the stuck-button detector;
//             when undefined travado is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module condicionador_botoes
    import condicionador_botoes_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = C_DEBOUNCE_CICLOS_PADRAO,
    parameter int TRAVADO_CICLOS  = C_TRAVADO_CICLOS_PADRAO
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [C_LARGURA_BOTOES-1:0] botoes,
    input  logic                        limpa,
    output logic [C_LARGURA_BOTOES-1:0] jogada,
    output logic                        jogada_feita,
    output logic                        db_tem_jogada,
    output logic                        travado,
    output logic [2:0]                  db_estado
);

    localparam int CONT_MAX     = (DEBOUNCE_CICLOS > TRAVADO_CICLOS) ?
                                  DEBOUNCE_CICLOS : TRAVADO_CICLOS;
    localparam int LARGURA_CONT = $clog2(CONT_MAX + 1);

    // Counter stops at these terminal values; it is never allowed past them.
    localparam logic [LARGURA_CONT-1:0] FIM_DEBOUNCE = LARGURA_CONT'(DEBOUNCE_CICLOS - 1);
    localparam logic [LARGURA_CONT-1:0] UM           = LARGURA_CONT'(1);

    logic [C_LARGURA_BOTOES-1:0] s;

    estado_t                     estado_q,    estado_d;
    logic [C_LARGURA_BOTOES-1:0] candidato_q, candidato_d;
    logic [LARGURA_CONT-1:0]     contador_q,  contador_d;
    logic [C_LARGURA_BOTOES-1:0] jogada_q,    jogada_d;

    sincronizador #(
        .LARGURA (C_LARGURA_BOTOES)
    ) u_sincronizador (
        .clock (clock),
        .reset (reset),
        .d     (botoes),
        .q     (s)
    );

`ifdef CONDICIONADOR_TRAVADO_EN
    localparam logic [LARGURA_CONT-1:0] FIM_TRAVADO = LARGURA_CONT'(TRAVADO_CICLOS - 1);
    logic travado_q, travado_d;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q    <= OCIOSO;
            candidato_q <= '0;
            contador_q  <= '0;
            jogada_q    <= '0;
`ifdef CONDICIONADOR_TRAVADO_EN
            travado_q   <= 1'b0;
`endif
        end else begin
            estado_q    <= estado_d;
            candidato_q <= candidato_d;
            contador_q  <= contador_d;
            jogada_q    <= jogada_d;
`ifdef CONDICIONADOR_TRAVADO_EN
            travado_q   <= travado_d;
`endif
        end
    end

    always_comb begin
        estado_d    = estado_q;
        candidato_d = candidato_q;
        contador_d  = contador_q;
        jogada_d    = jogada_q;
`ifdef CONDICIONADOR_TRAVADO_EN
        travado_d   = travado_q;
`endif
        // Placed first so a simultaneous VALIDA load below overrides it.
        if (limpa) begin
            jogada_d = '0;
        end

        case (estado_q)
            OCIOSO: begin
                if (s != '0) begin
                    candidato_d = s;
                    contador_d  = '0;
                    estado_d    = FILTRA;
                end
            end
            FILTRA: begin
                if (s != candidato_q) begin
                    estado_d = OCIOSO;
                end else if (contador_q == FIM_DEBOUNCE) begin
                    contador_d = '0;
                    if (eh_one_hot(candidato_q)) begin
                        estado_d = VALIDA;
                        jogada_d = candidato_q;
                    end else begin
                        // Chords are swallowed: wait for release, no pulse.
                        estado_d = ESPERA_SOLTA;
                    end
                end else begin
                    contador_d = contador_q + UM;
                end
            end
            VALIDA: begin
                contador_d = '0;
                estado_d   = ESPERA_SOLTA;
            end
            ESPERA_SOLTA: begin
                if (s == '0) begin
                    contador_d = '0;
                    estado_d   = FILTRA_SOLTA;
`ifdef CONDICIONADOR_TRAVADO_EN
                    travado_d  = 1'b0;
                end else if (contador_q == FIM_TRAVADO) begin
                    travado_d  = 1'b1;
                end else begin
                    contador_d = contador_q + UM;
`endif
                end
            end
            FILTRA_SOLTA: begin
                if (s != '0) begin
                    // Release bounce: keep waiting, never re-arm a press.
                    contador_d = '0;
                    estado_d   = ESPERA_SOLTA;
                end else if (contador_q == FIM_DEBOUNCE) begin
                    estado_d = OCIOSO;
                end else begin
                    contador_d = contador_q + UM;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    assign jogada        = jogada_q;
    assign jogada_feita  = (estado_q == VALIDA);
    assign db_tem_jogada = |s;
    assign db_estado     = estado_q;
`ifdef CONDICIONADOR_TRAVADO_EN
    assign travado       = travado_q;
`else
    assign travado       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_condicionador_botoes.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_condicionador_botoes
//  Purpose  : Directed self-checking bench for condicionador_botoes with
//             DEBOUNCE_CICLOS=4 and TRAVADO_CICLOS=20. Honours
//             CONDICIONADOR_TRAVADO_EN for the travado expectation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_condicionador_botoes;

`ifdef CONDICIONADOR_TRAVADO_EN
    localparam logic TRAV_ESPERADO = 1'b1;
`else
    localparam logic TRAV_ESPERADO = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] botoes;
    logic       limpa;
    logic [3:0] jogada;
    logic       jogada_feita;
    logic       db_tem_jogada;
    logic       travado;
    logic [2:0] db_estado;

    int n_checks = 0;
    int n_errors = 0;
    int pulsos;
    int borda;

    condicionador_botoes #(
        .DEBOUNCE_CICLOS (4),
        .TRAVADO_CICLOS  (20)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .botoes        (botoes),
        .limpa         (limpa),
        .jogada        (jogada),
        .jogada_feita  (jogada_feita),
        .db_tem_jogada (db_tem_jogada),
        .travado       (travado),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset  = 1'b0;
        botoes = 4'b0000;
        limpa  = 1'b0;
        tick();
        tick();
        check("rst_jogada",       jogada,        4'b0000);
        check("rst_feita",        jogada_feita,  1'b0);
        check("rst_tem_jogada",   db_tem_jogada, 1'b0);
        check("rst_travado",      travado,       1'b0);
        check("rst_estado",       db_estado,     3'd0);
        reset = 1'b1;
        tick();

        // Single clean press of button 1 held 30 cycles.
        botoes = 4'b0010;
        pulsos = 0;
        borda  = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (jogada_feita) begin
                pulsos++;
                borda = k;
            end
            if (k == 7)  check("t1_jogada_no_pulso", jogada, 4'b0010);
            if (k == 10) begin
                check("t1_estado_espera", db_estado, 3'd3);
                check("t1_tem_jogada", db_tem_jogada, 1'b1);
            end
            if (k == 27) check("t1_travado_antes", travado, 1'b0);
            if (k == 28) check("t1_travado_limite", travado, TRAV_ESPERADO);
        end
        botoes = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (jogada_feita) pulsos++;
            if (k == 3) begin
                check("t1_estado_filtra_solta", db_estado, 3'd4);
                check("t1_travado_solto", travado, 1'b0);
            end
        end
        check("t1_num_pulsos", pulsos, 1);
        check("t1_borda_pulso", borda, 7);
        check("t1_jogada_final", jogada, 4'b0010);
        check("t1_estado_final", db_estado, 3'd0);

        // Bouncing button 2: never stable for the full window.
        pulsos = 0;
        for (int c = 0; c < 20; c++) begin
            botoes = (((c / 2) % 2) == 0) ? 4'b0100 : 4'b0000;
            tick();
            if (jogada_feita) pulsos++;
        end
        botoes = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (jogada_feita) pulsos++;
        end
        check("t2_num_pulsos", pulsos, 0);
        check("t2_jogada", jogada, 4'b0010);
        check("t2_estado", db_estado, 3'd0);

        // Two buttons at once: filtered then discarded.
        pulsos = 0;
        botoes = 4'b0011;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (jogada_feita) pulsos++;
        end
        check("t3_estado_espera", db_estado, 3'd3);
        check("t3_num_pulsos", pulsos, 0);
        check("t3_jogada", jogada, 4'b0010);
        botoes = 4'b0000;
        for (int k = 0; k < 12; k++) tick();
        check("t3_estado_final", db_estado, 3'd0);

        // limpa coinciding with the VALIDA load, then limpa alone.
        pulsos = 0;
        botoes = 4'b1000;
        for (int k = 1; k <= 10; k++) begin
            if (k == 7) limpa = 1'b1;
            tick();
            if (jogada_feita) pulsos++;
            if (k == 7) begin
                limpa = 1'b0;
                check("t4_feita_com_limpa", jogada_feita, 1'b1);
                check("t4_jogada_com_limpa", jogada, 4'b1000);
            end
        end
        check("t4_num_pulsos", pulsos, 1);
        botoes = 4'b0000;
        for (int k = 0; k < 12; k++) tick();
        check("t4_jogada_antes_limpa", jogada, 4'b1000);
        limpa = 1'b1;
        tick();
        limpa = 1'b0;
        check("t4_jogada_limpa", jogada, 4'b0000);

        // Reset asserted mid-filter with the button still held.
        botoes = 4'b0001;
        for (int k = 0; k < 4; k++) tick();
        check("t5_estado_filtra", db_estado, 3'd1);
        #1;
        reset = 1'b0;
        #1;
        check("t5_rst_jogada",     jogada,        4'b0000);
        check("t5_rst_feita",      jogada_feita,  1'b0);
        check("t5_rst_tem_jogada", db_tem_jogada, 1'b0);
        check("t5_rst_travado",    travado,       1'b0);
        check("t5_rst_estado",     db_estado,     3'd0);
        tick();
        reset  = 1'b1;
        pulsos = 0;
        borda  = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (jogada_feita) begin
                pulsos++;
                borda = k;
            end
        end
        check("t5_num_pulsos", pulsos, 1);
        check("t5_borda_pulso", borda, 7);
        check("t5_jogada", jogada, 4'b0001);
        botoes = 4'b0000;
        for (int k = 0; k < 12; k++) tick();
        check("t5_estado_final", db_estado, 3'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/condicionador_botoes.md
CONDICIONADOR_BOTOES -- requirements
Module: condicionador_botoes

Interface
REQ-001 Parameter DEBOUNCE_CICLOS, default 50000, SHALL set the press/release stability window in clock cycles (legal range 2..2^20).
REQ-002 Parameter TRAVADO_CICLOS, default 5000000, SHALL set the held-button limit in clock cycles used by the stuck-button feature.
REQ-003 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 botoes  in  4  SHALL be the raw, asynchronous, active-high player buttons.
REQ-006 limpa  in  1  SHALL be a synchronous clear of the held jogada code.
REQ-007 jogada  out  4  SHALL hold the last validated one-hot button code feeding the game datapath.
REQ-008 jogada_feita  out  1  SHALL be a single-cycle pulse marking each validated press.
REQ-009 db_tem_jogada  out  1  SHALL be high while any synchronized button bit is high.
REQ-010 travado  out  1  SHALL flag a button held beyond TRAVADO_CICLOS.
REQ-011 db_estado  out  3  SHALL expose the FSM state code.

Function
REQ-012 botoes SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value s.
REQ-013 FSM states and codes SHALL be OCIOSO=0, FILTRA=1, VALIDA=2, ESPERA_SOLTA=3, FILTRA_SOLTA=4.
REQ-014 In OCIOSO with s!=0, the FSM SHALL capture candidato=s, clear the counter and go to FILTRA.
REQ-015 In FILTRA, s!=candidato SHALL return to OCIOSO; otherwise the counter increments.
REQ-016 FILTRA SHALL last exactly DEBOUNCE_CICLOS cycles when s is stable; it then goes to VALIDA if candidato is one-hot, else to ESPERA_SOLTA with no pulse.
REQ-017 On entry to VALIDA, jogada SHALL load candidato, and jogada_feita SHALL be high only while in VALIDA (one cycle). The next state is ESPERA_SOLTA.
REQ-018 Latency: press applied before rising edge 1 SHALL produce jogada_feita in the cycle after edge DEBOUNCE_CICLOS+3.
REQ-019 In ESPERA_SOLTA, s==0 SHALL clear the counter and go to FILTRA_SOLTA; further presses or added buttons SHALL be ignored.
REQ-020 In FILTRA_SOLTA, s!=0 SHALL return to ESPERA_SOLTA; after DEBOUNCE_CICLOS cycles of s==0 the FSM goes to OCIOSO.
REQ-021 Each physical press SHALL produce at most one jogada_feita pulse, regardless of bounce or hold time.
REQ-022 limpa SHALL clear jogada to 0 on the next edge; if limpa and entry to VALIDA coincide, the VALIDA load SHALL win.
REQ-023 The counter SHALL be wide enough for max(DEBOUNCE_CICLOS, TRAVADO_CICLOS) and SHALL never wrap; it saturates at its terminal value.

Reset
REQ-024 Reset low SHALL immediately force OCIOSO and clear the synchronizer, candidato, counter, jogada, jogada_feita, travado, db_tem_jogada and db_estado to 0, including when asserted mid-filter.
REQ-025 After reset release, a button already held SHALL be treated as a new press through the full FILTRA window.

Configuration
REQ-026 With macro CONDICIONADOR_TRAVADO_EN defined, travado SHALL assert once ESPERA_SOLTA has lasted TRAVADO_CICLOS cycles with s!=0, and clear on leaving ESPERA_SOLTA.
REQ-027 Without CONDICIONADOR_TRAVADO_EN, the port travado SHALL remain present and be tied to 0, and no hold counter logic SHALL be built.

Structure
REQ-028 The state codes, the default DEBOUNCE_CICLOS and TRAVADO_CICLOS values, and the button width (4) SHALL live in a shared package/include file.
REQ-029 The 2-flop synchronizer SHALL be a separate sub-module named sincronizador, instantiated with width 4.

Verification
REQ-030 Use DEBOUNCE_CICLOS=4 and TRAVADO_CICLOS=20. Hold botoes=0010 for 30 cycles, then release. Required: exactly one jogada_feita pulse in the cycle after edge 7, jogada=0010 afterwards, and db_estado returns to 0.
REQ-031 Toggle botoes 0100/0000 every 2 cycles for 20 cycles. Required: no jogada_feita pulse, and jogada stays unchanged.
REQ-032 Press botoes=0011 stably for 10 cycles. Required: no pulse, jogada unchanged, FSM reaches ESPERA_SOLTA (db_estado=3).
REQ-033 Pulse limpa in the same cycle as VALIDA with botoes=1000. Required: jogada=1000. Pulse limpa alone later. Required: jogada=0000.
REQ-034 With CONDICIONADOR_TRAVADO_EN, hold botoes=0001 for 40 cycles. Required: travado=1 after 20 cycles in ESPERA_SOLTA, cleared on release. Without the macro, travado stays 0.
REQ-035 Drive reset low during FILTRA with botoes=0001 held. Required: all outputs are 0 immediately, and after release one pulse occurs DEBOUNCE_CICLOS+3 edges later.
